alu_arbiter: RTL and testbench

Shares the single combinational ALU between NUM_REQ requesters. Each requester issues an operation with a valid/ready handshake. A round-robin arbiter selects one request, registers its operands and opcode onto the ALU inputs, captures the ALU result, and returns it with the requester index over a shared response channel. It sits between the issue logic and the ALU, and is the only block that drives the ALU inputs.

---
 rtl/alu_arbiter.sv | 106 ++++++++++
 tb/tb_alu_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between NUM_REQ valid/ready requesters.
// Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
package alu_arbiter_pkg;
  typedef logic [3:0] alu_opt_t;
  localparam alu_opt_t alu_control_add = 4'd0;
  localparam alu_opt_t alu_control_sub = 4'd1;
  localparam alu_opt_t alu_control_and = 4'd2;
  localparam alu_opt_t alu_control_or  = 4'd3;
  localparam alu_opt_t alu_control_xor = 4'd4;
endpackage

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic     [NUM_REQ-1:0]            req_valid,
  output logic     [NUM_REQ-1:0]            req_ready,
  input  alu_opt_t [NUM_REQ-1:0]            req_op,
  input  logic     [NUM_REQ-1:0][DATA_WIDTH:0] req_a,
  input  logic     [NUM_REQ-1:0][DATA_WIDTH:0] req_b,
  output logic     [DATA_WIDTH:0]           alu_ain,
  output logic     [DATA_WIDTH:0]           alu_bin,
  output alu_opt_t                          alu_control,
  input  logic     [DATA_WIDTH:0]           alu_result,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic     [DATA_WIDTH:0]           rsp_data,
  output logic     [ID_W-1:0]               rsp_id
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [DATA_WIDTH:0] ain_q, ain_d, bin_q, bin_d, data_q, data_d;
  alu_opt_t            op_q, op_d;
  logic [ID_W-1:0]     id_q, id_d, ptr, gnt_id, idx;
  logic                gnt_v, take;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  assign ptr = rr_ptr_q;
  assign rr_ptr_d = take ? ((gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1) : rr_ptr_q;
  always_ff @(posedge clk) begin
    rr_ptr_q <= rst ? '0 : rr_ptr_d;
  end
`endif

  // Reverse scan: the last match written is the first index in priority order.
  always_comb begin
    gnt_v = 1'b0;
    gnt_id = '0;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (req_valid[idx]) begin
        gnt_v = 1'b1;
        gnt_id = idx;
      end
    end
  end

  assign take      = state_q == IDLE && gnt_v;
  assign req_ready = take ? NUM_REQ'(1) << gnt_id : '0;

  always_comb begin
    state_d = take ? EXEC : (state_q == EXEC) ? RESP : (state_q == RESP && !rsp_ready) ? RESP : IDLE;
    ain_d = take ? req_a[gnt_id] : ain_q;
    bin_d = take ? req_b[gnt_id] : bin_q;
    op_d = take ? req_op[gnt_id] : op_q;
    id_d = take ? gnt_id : id_q;
    data_d = (state_q == EXEC) ? alu_result : data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ain_q <= '0;
      bin_q <= '0;
      op_q <= alu_control_add;
      id_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      ain_q <= ain_d;
      bin_q <= bin_d;
      op_q <= op_d;
      id_q <= id_d;
      data_q <= data_d;
    end
  end

  assign alu_ain     = ain_q;
  assign alu_bin     = bin_q;
  assign alu_control = op_q;
  assign rsp_valid   = state_q == RESP;
  assign rsp_data    = data_q;
  assign rsp_id      = id_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a cycle-level reference model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;
  localparam int DW = 16;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct {
    logic [IW-1:0] id;
    logic [DW:0]   data;
  } rsp_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic     [N-1:0]       req_valid = '0;
  logic     [N-1:0]       req_ready;
  alu_opt_t [N-1:0]       req_op = '0;
  logic     [N-1:0][DW:0] req_a = '0;
  logic     [N-1:0][DW:0] req_b = '0;
  logic     [DW:0]        alu_ain, alu_bin, alu_result, rsp_data;
  alu_opt_t               alu_control;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b0;
  logic     [IW-1:0]      rsp_id;

  function automatic logic [DW:0] tb_alu(input alu_opt_t op, input logic [DW:0] a, input logic [DW:0] b);
    case (op)
      alu_control_add: return a + b;
      alu_control_sub: return a - b;
      alu_control_and: return a & b;
      alu_control_or:  return a | b;
      alu_control_xor: return a ^ b;
      default:         return ~a;
    endcase
  endfunction

  assign alu_result = tb_alu(alu_control, alu_ain, alu_bin);

  alu_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_ain(alu_ain), .alu_bin(alu_bin), .alu_control(alu_control), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int          cyc = 0;
  logic [N-1:0] last_gnt = '0;
  logic [1:0]  m_state = S_IDLE;
  int          m_ptr = 0;
  logic [IW-1:0] m_id = '0;
  logic [DW:0] m_a = '0, m_b = '0, m_data = '0;
  alu_opt_t    m_op = alu_control_add;
  rsp_t        sb[$];
  int          gnt_log[$];
  int          gnt_cyc[$];
  int          id1_cnt = 0;
  bit          one_shot = 1'b1;

  // Reference model: compare this cycle's outputs, then advance using this cycle's inputs.
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    int g;
    bit found;
    rsp_t e;
    cyc++;
    last_gnt = req_ready;
    if (rst) begin
      m_state = S_IDLE; m_ptr = 0; m_id = '0; m_a = '0; m_b = '0; m_data = '0;
      m_op = alu_control_add;
      sb.delete();
    end else begin
      found = 1'b0;
      g = 0;
      if (m_state == S_IDLE)
        for (int n = 0; n < N; n++)
          if (!found && req_valid[(m_ptr + n) % N]) begin
            found = 1'b1;
            g = (m_ptr + n) % N;
          end
      exp_rdy = '0;
      if (found) exp_rdy[g] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("rsp_valid", 32'(rsp_valid), 32'(m_state == S_RESP));
      check("rsp_id", 32'(rsp_id), 32'(m_id));
      check("rsp_data", 32'(rsp_data), 32'(m_data));
      check("alu_ain", 32'(alu_ain), 32'(m_a));
      check("alu_bin", 32'(alu_bin), 32'(m_b));
      check("alu_control", 32'(alu_control), 32'(m_op));
      if (found) begin
        m_op = req_op[g]; m_a = req_a[g]; m_b = req_b[g]; m_id = IW'(g);
        m_ptr = FIXED ? 0 : (g + 1) % N;
        e.id = IW'(g);
        e.data = tb_alu(req_op[g], req_a[g], req_b[g]);
        sb.push_back(e);
        gnt_log.push_back(g);
        gnt_cyc.push_back(cyc);
        m_state = S_EXEC;
      end else if (m_state == S_EXEC) begin
        m_data = tb_alu(m_op, m_a, m_b);
        m_state = S_RESP;
      end else if (m_state == S_RESP && rsp_ready) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("sb_id", 32'(rsp_id), 32'(e.id));
          check("sb_data", 32'(rsp_data), 32'(e.data));
        end else check("sb_underflow", 32'(sb.size()), 32'd1);
        if (rsp_id == IW'(1)) id1_cnt++;
        m_state = S_IDLE;
      end
    end
  end

  task automatic set_payload(input int k);
    req_op[k] = alu_opt_t'($urandom_range(0, 7));
    req_a[k] = (DW + 1)'($urandom);
    req_b[k] = (DW + 1)'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++)
      if (last_gnt[k]) begin
        if (one_shot) req_valid[k] = 1'b0;
        else set_payload(k);
      end
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (rsp_valid) break;
      tick();
      n++;
    end
    check(tag, 32'(rsp_valid), 32'd1);
  endtask

  initial begin
    logic [DW:0] hd;
    logic [IW-1:0] hi;
    int n;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_alu_control", 32'(alu_control), 32'(alu_control_add));

    // single request on index 2
    tick();
    req_op[2] = alu_control_add; req_a[2] = 17'd5; req_b[2] = 17'd7; req_valid[2] = 1'b1;
    @(negedge clk);
    check("t1_ready", 32'(req_ready), 32'b0100);
    tick();
    @(negedge clk);
    check("t1_exec_no_rsp", 32'(rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_rsp_data", 32'(rsp_data), 32'd12);
    check("t1_rsp_id", 32'(rsp_id), 32'd2);
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    check("t1_back_idle", 32'(rsp_valid), 32'd0);

    // all requesters continuously valid
    tick();
    one_shot = 1'b0; rsp_ready = 1'b1;
    gnt_log.delete(); gnt_cyc.delete();
    for (int k = 0; k < N; k++) set_payload(k);
    req_valid = '1;
    n = 0;
    while (gnt_log.size() < 5 && n < 40) begin tick(); n++; end
    req_valid = '0;
    check("t2_count", 32'(gnt_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < gnt_log.size(); i++)
      check("t2_order", 32'(gnt_log[i]), FIXED ? 32'd0 : 32'((3 + i) % N));
    for (int i = 1; i < 5 && i < gnt_cyc.size(); i++)
      check("t2_gap", 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd3);
    repeat (4) tick();

    // backpressure
    one_shot = 1'b1; rsp_ready = 1'b0;
    set_payload(1); req_valid[1] = 1'b1;
    wait_rsp("t3_rsp_timeout");
    hd = rsp_data; hi = rsp_id;
    tick();
    set_payload(0); req_valid[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t3_hold_data", 32'(rsp_data), 32'(hd));
      check("t3_hold_id", 32'(rsp_id), 32'(hi));
      check("t3_no_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("t3_next_grant", 32'(req_ready), 32'b0001);
    repeat (4) tick();

    // wrap-around from index 3 back to 0
    gnt_log.delete();
    set_payload(0); set_payload(3);
    req_valid = 4'b1001;
    repeat (10) tick();
    check("t4_count", 32'(gnt_log.size()), 32'd2);
    if (gnt_log.size() == 2) begin
      check("t4_first", 32'(gnt_log[0]), FIXED ? 32'd0 : 32'd3);
      check("t4_second", 32'(gnt_log[1]), FIXED ? 32'd3 : 32'd0);
    end

    // reset while in RESP
    rsp_ready = 1'b0;
    set_payload(2); req_valid[2] = 1'b1;
    wait_rsp("t5_rsp_timeout");
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_payload(0); set_payload(3);
    req_valid = 4'b1001; rsp_ready = 1'b1;
    @(negedge clk);
    check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t5_rsp_id", 32'(rsp_id), 32'd0);
    check("t5_rsp_data", 32'(rsp_data), 32'd0);
    check("t5_ptr_reset", 32'(req_ready), 32'b0001);
    repeat (10) tick();

    // request pulsed during EXEC is dropped
    gnt_log.delete(); id1_cnt = 0;
    set_payload(0); req_valid[0] = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (req_ready[0]) break;
      tick();
      n++;
    end
    check("t6_grant0", 32'(req_ready[0]), 32'd1);
    tick();
    set_payload(1); req_valid[1] = 1'b1;
    @(negedge clk);
    check("t6_no_grant_exec", 32'(req_ready), 32'd0);
    tick();
    req_valid[1] = 1'b0;
    repeat (6) tick();
    check("t6_grants", 32'(gnt_log.size()), 32'd1);
    check("t6_no_id1_rsp", 32'(id1_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
